// File: rtl/tube_bcd_feeder.sv
// Bus-side feeder for the 8-digit seven-segment tube controller.
// Converts one bus word to packed BCD (or passes it as hex), then issues an MSB/LSB write pair.
module tube_bcd_feeder #(
  parameter int CPU_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hex_mode,
  input  logic [CPU_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 tube_we,
  output logic [CPU_WIDTH-1:0] tube_data
);

  localparam int LP_BCD_W = 2 * CPU_WIDTH;
  localparam int LP_CNT_W = $clog2(CPU_WIDTH);
  localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(CPU_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WR_HI,
    S_WR_LO
  } state_t;

  state_t                r_state;
  logic [LP_BCD_W-1:0]   r_bcd;
  logic [CPU_WIDTH-1:0]  r_bin;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_we;
  logic [CPU_WIDTH-1:0]  r_data;
  logic [LP_BCD_W-1:0]   w_bcd_adj;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < LP_BCD_W / 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // busy is cleared one cycle after the last write so it covers the final IDLE
  // transition; a start taken in that IDLE cycle keeps it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we   <= 1'b0;
          r_busy <= start;
          if (start) begin
            if (hex_mode) begin
              r_bcd   <= {{(LP_BCD_W - CPU_WIDTH){1'b0}}, bin_in};
              r_state <= S_WR_HI;
            end else begin
              r_bin   <= bin_in;
              r_bcd   <= '0;
              r_cnt   <= '0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_we  <= 1'b0;
          r_bcd <= {w_bcd_adj[LP_BCD_W-2:0], r_bin[CPU_WIDTH-1]};
          r_bin <= {r_bin[CPU_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_state <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          r_we    <= 1'b1;
          r_data  <= r_bcd[LP_BCD_W-1:CPU_WIDTH];
          r_state <= S_WR_LO;
        end
        S_WR_LO: begin
          r_we    <= 1'b1;
          r_data  <= r_bcd[CPU_WIDTH-1:0];
          r_state <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign tube_we   = r_we;
  assign tube_data = r_data;

endmodule

// File: tb/tb_tube_bcd_feeder.sv
// Scoreboard bench for tube_bcd_feeder: expected write words are queued at stimulus
// time and consumed by a monitor that also models the tube controller's pair latch.
module tb_tube_bcd_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hex_mode;
  logic [15:0] bin_in;
  logic        busy;
  logic        tube_we;
  logic [15:0] tube_data;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_we;

  logic [15:0] exp_q[$];
  logic [31:0] tube_q[$];

  tube_bcd_feeder #(.CPU_WIDTH(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hex_mode (hex_mode),
    .bin_in   (bin_in),
    .busy     (busy),
    .tube_we  (tube_we),
    .tube_data(tube_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] expect_word(input logic hx, input logic [15:0] v);
    return hx ? {16'h0000, v} : to_bcd(int'(v));
  endfunction

  task automatic push_exp(input logic hx, input logic [15:0] v);
    logic [31:0] w;
    w = expect_word(hx, v);
    exp_q.push_back(w[31:16]);
    exp_q.push_back(w[15:0]);
    tube_q.push_back(w);
  endtask

  // Monitor + tube controller model (half-word toggle reset by the shared rst_n).
  logic        m_half;
  logic [15:0] m_hi;
  logic [15:0] m_last;
  int unsigned m_run;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_half = 1'b0;
      m_run  = 0;
      m_last = '0;
    end else if (tube_we) begin
      n_we++;
      m_run++;
      check("we_run_le2", 32'(m_run <= 2), 32'd1);
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wdata", {16'h0, tube_data}, {16'h0, exp_q.pop_front()});
      m_last = tube_data;
      if (!m_half) begin
        m_hi = tube_data;
      end else if (tube_q.size() != 0) begin
        check("tube_latch", {m_hi, tube_data}, tube_q.pop_front());
      end
      m_half = ~m_half;
    end else begin
      m_run = 0;
      check("data_hold", {16'h0, tube_data}, {16'h0, m_last});
    end
  end

  task automatic start_req(input logic hx, input logic [15:0] v, input bit push);
    @(negedge clk);
    start    = 1'b1;
    hex_mode = hx;
    bin_in   = v;
    if (push) push_exp(hx, v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (!busy && exp_q.size() == 0) break;
    end
    check("idle_reached", 32'(!busy && exp_q.size() == 0), 32'd1);
  endtask

  // Cycle-exact latency check; cycle 0 is the edge that samples start.
  task automatic timed_run(input logic hx, input logic [15:0] v);
    int unsigned w1;
    int unsigned bf;
    w1 = hx ? 1 : 17;
    bf = hx ? 3 : 19;
    start_req(hx, v, 1'b1);
    for (int unsigned i = 1; i <= bf + 1; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("we_c%0d", i), {31'h0, tube_we}, 32'(i == w1 || i == w1 + 1));
      check($sformatf("busy_c%0d", i), {31'h0, busy}, 32'(i < bf));
    end
    wait_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_we     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    hex_mode = 1'b0;
    bin_in   = '0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_we", {31'h0, tube_we}, 32'h0);
    check("rst_data", {16'h0, tube_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    timed_run(1'b0, 16'd12345);
    timed_run(1'b0, 16'd0);
    timed_run(1'b0, 16'd65535);
    timed_run(1'b0, 16'd9999);
    timed_run(1'b1, 16'hBEEF);

    // start held high with alternating values: only IDLE cycles accept it.
    @(negedge clk);
    for (int k = 0; k < 57; k++) begin
      start    = 1'b1;
      hex_mode = 1'b0;
      bin_in   = (k % 2 == 0) ? 16'd2468 : 16'd13579;
      if (k % 19 == 0) push_exp(1'b0, bin_in);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset mid-SHIFT: the aborted conversion must emit nothing.
    start_req(1'b0, 16'd777, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_we", {31'h0, tube_we}, 32'h0);
    check("midrst_data", {16'h0, tube_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_req(1'b0, 16'd4321, 1'b1);
    wait_idle();

    // start during WR_HI and WR_LO must be ignored.
    begin
      int unsigned we0;
      we0 = n_we;
      start_req(1'b0, 16'd31415, 1'b1);
      repeat (16) @(negedge clk);
      start    = 1'b1;
      hex_mode = 1'b1;
      bin_in   = 16'hDEAD;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("ign_busy_c19", {31'h0, busy}, 32'h0);
      wait_idle();
      repeat (5) @(posedge clk);
      #2;
      check("ign_we_count", n_we - we0, 32'd2);
    end

    check("tube_q_empty", tube_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
